// File: rtl/am_search_engine.sv
// Associative-memory search engine: streams a query HV against NUM_CLASSES stored class HVs,
// SEG_W bits per cycle, then reports a registered argmax and a saturating accuracy tally.
module am_search_engine #(
  parameter int HV_DIM      = 80,
  parameter int SEG_W       = 8,
  parameter int NUM_CLASSES = 26,
  parameter int CLASS_W     = $clog2(NUM_CLASSES),
  parameter int SIM_W       = $clog2(HV_DIM + 1),
  parameter int TALLY_W     = 11
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic                          sim_mode,
  input  logic                          query_valid,
  output logic                          query_ready,
  input  logic [HV_DIM-1:0]             query_hv,
  input  logic [CLASS_W-1:0]            correct_class,
  input  logic [NUM_CLASSES*HV_DIM-1:0] class_hvs,
  input  logic                          tally_en,
  input  logic                          clear_tally,
  output logic                          result_valid,
  output logic [CLASS_W-1:0]            class_inference,
  output logic [SIM_W-1:0]              best_similarity,
  output logic                          tie_flag,
  output logic [TALLY_W-1:0]            number_of_correct_inferences
);
  localparam int NUM_SEG = (HV_DIM + SEG_W - 1) / SEG_W;
  localparam int PAD_W   = NUM_SEG * SEG_W;
  localparam int SEG_CW  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [SEG_CW-1:0]  LAST_SEG  = SEG_CW'(NUM_SEG - 1);
  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;
  state_t state;

  logic [PAD_W-1:0]   q_reg;
  logic [CLASS_W-1:0] correct_q;
  logic               mode_q;
  logic               tally_en_q;
  logic [SEG_CW-1:0]  seg_ctr;
  logic [SIM_W-1:0]   acc [NUM_CLASSES];

  logic [PAD_W-1:0]   mask_full;
  logic [PAD_W-1:0]   cls_pad;
  logic [SEG_W-1:0]   q_seg;
  logic [SEG_W-1:0]   c_seg;
  logic [SEG_W-1:0]   mask_seg;
  logic [SIM_W-1:0]   seg_sim [NUM_CLASSES];
  logic [CLASS_W-1:0] arg_idx;
  logic [SIM_W-1:0]   arg_max;
  logic               arg_tie;

  function automatic logic [SIM_W-1:0] popcount(input logic [SEG_W-1:0] v);
    logic [SIM_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < SEG_W; i++) n += SIM_W'(v[i]);
    return n;
  endfunction

  // Pad bits of the final segment are masked so they never score, even under XNOR.
  always_comb begin
    mask_full = '0;
    for (int unsigned i = 0; i < PAD_W; i++) mask_full[i] = (i < HV_DIM);
  end

  always_comb begin
    q_seg    = q_reg[int'(seg_ctr)*SEG_W +: SEG_W];
    mask_seg = mask_full[int'(seg_ctr)*SEG_W +: SEG_W];
    cls_pad  = '0;
    c_seg    = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      cls_pad    = PAD_W'(class_hvs[c*HV_DIM +: HV_DIM]);
      c_seg      = cls_pad[int'(seg_ctr)*SEG_W +: SEG_W];
      seg_sim[c] = popcount((mode_q ? ~(q_seg ^ c_seg) : (q_seg & c_seg)) & mask_seg);
    end
  end

  // Strict '>' keeps the lowest index on ties; tie is cleared whenever a new max appears.
  always_comb begin
    arg_idx = '0;
    arg_max = acc[0];
    arg_tie = 1'b0;
    for (int unsigned c = 1; c < NUM_CLASSES; c++) begin
      if (acc[c] > arg_max) begin
        arg_max = acc[c];
        arg_idx = CLASS_W'(c);
        arg_tie = 1'b0;
      end else if (acc[c] == arg_max) begin
        arg_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state                        <= IDLE;
      query_ready                  <= 1'b1;
      result_valid                 <= 1'b0;
      class_inference              <= '0;
      best_similarity              <= '0;
      tie_flag                     <= 1'b0;
      number_of_correct_inferences <= '0;
      q_reg                        <= '0;
      correct_q                    <= '0;
      mode_q                       <= 1'b0;
      tally_en_q                   <= 1'b0;
      seg_ctr                      <= '0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
    end else begin
      if (clear_tally)
        number_of_correct_inferences <= '0;
      else if (en && state == DONE && tally_en_q && class_inference == correct_q &&
               number_of_correct_inferences != TALLY_MAX)
        number_of_correct_inferences <= number_of_correct_inferences + 1'b1;

      if (en) begin
        case (state)
          IDLE: begin
            if (query_valid && query_ready) begin
              q_reg       <= PAD_W'(query_hv);
              correct_q   <= correct_class;
              mode_q      <= sim_mode;
              tally_en_q  <= tally_en;
              seg_ctr     <= '0;
              for (int unsigned c = 0; c < NUM_CLASSES; c++) acc[c] <= '0;
              query_ready <= 1'b0;
              state       <= ACCUM;
            end
          end
          ACCUM: begin
            for (int unsigned c = 0; c < NUM_CLASSES; c++) acc[c] <= acc[c] + seg_sim[c];
            seg_ctr <= seg_ctr + 1'b1;
            if (seg_ctr == LAST_SEG) state <= COMPARE;
          end
          COMPARE: begin
            class_inference <= arg_idx;
            best_similarity <= arg_max;
            tie_flag        <= arg_tie;
            result_valid    <= 1'b1;
            state           <= DONE;
          end
          DONE: begin
            result_valid <= 1'b0;
            query_ready  <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_am_search_engine.sv
// Scoreboard bench for am_search_engine: a default 80-bit instance and an 84-bit instance
// with pad bits, directed queries with hand-derived expected results.
module tb_am_search_engine;
  logic clk = 1'b0;
  logic nrst, en, clear_tally;
  always #5 clk = ~clk;

  logic        mode0, qv0, qr0, te0, rv0, tf0;
  logic [79:0] qhv0;
  logic [4:0]  cc0, ci0;
  logic [26*80-1:0] chv0;
  logic [6:0]  bs0;
  logic [10:0] tal0;

  logic        mode1, qv1, qr1, te1, rv1, tf1;
  logic [83:0] qhv1;
  logic [4:0]  cc1, ci1;
  logic [26*84-1:0] chv1;
  logic [6:0]  bs1;
  logic [10:0] tal1;

  am_search_engine d0 (
    .clk(clk), .nrst(nrst), .en(en), .sim_mode(mode0), .query_valid(qv0), .query_ready(qr0),
    .query_hv(qhv0), .correct_class(cc0), .class_hvs(chv0), .tally_en(te0),
    .clear_tally(clear_tally), .result_valid(rv0), .class_inference(ci0),
    .best_similarity(bs0), .tie_flag(tf0), .number_of_correct_inferences(tal0));

  am_search_engine #(.HV_DIM(84)) d1 (
    .clk(clk), .nrst(nrst), .en(en), .sim_mode(mode1), .query_valid(qv1), .query_ready(qr1),
    .query_hv(qhv1), .correct_class(cc1), .class_hvs(chv1), .tally_en(te1),
    .clear_tally(clear_tally), .result_valid(rv1), .class_inference(ci1),
    .best_similarity(bs1), .tie_flag(tf1), .number_of_correct_inferences(tal1));

  typedef struct {int cyc; int cls; int sim; int tie; int tally;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int etal0 = 0;
  bit pend0 = 0, pend1 = 0;
  int ptal0, ptal1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [79:0] cls_hv(input int c);
    logic [79:0] v;
    v = 80'd7;
    return v << (3 * c);
  endfunction

  function automatic int next_tal(input int t, input bit te, input int corr, input int cls);
    if (te && corr == cls) return (t < 2047) ? t + 1 : t;
    return t;
  endfunction

  always @(negedge clk) begin
    if (pend0) begin
      check("d0_tally", int'(tal0), ptal0);
      pend0 = 0;
    end
    if (nrst && rv0 && en) begin
      check("d0_result_expected", int'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("d0_result_cycle", cyc, e0.cyc);
        check("d0_class", int'(ci0), e0.cls);
        check("d0_similarity", int'(bs0), e0.sim);
        check("d0_tie", int'(tf0), e0.tie);
        pend0 = 1;
        ptal0 = e0.tally;
      end
    end
  end

  always @(negedge clk) begin
    if (pend1) begin
      check("d1_tally", int'(tal1), ptal1);
      pend1 = 0;
    end
    if (nrst && rv1 && en) begin
      check("d1_result_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("d1_result_cycle", cyc, e1.cyc);
        check("d1_class", int'(ci1), e1.cls);
        check("d1_similarity", int'(bs1), e1.sim);
        check("d1_tie", int'(tf1), e1.tie);
        pend1 = 1;
        ptal1 = e1.tally;
      end
    end
  end

  task automatic send0(input logic [79:0] hv, input logic m, input int corr, input logic te,
                       input int ecls, input int esim, input int etie, input int extra,
                       input bit clr, input bit push, output int acc_cyc);
    exp_t e;
    int n;
    qhv0 = hv; mode0 = m; cc0 = 5'(corr); te0 = te; qv0 = 1'b1;
    n = 0;
    while (!(qr0 && en) && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!(qr0 && en)) begin
      check("d0_accept_timeout", int'(qr0 && en), 1);
      qv0 = 1'b0;
      return;
    end
    if (push) begin
      etal0 = clr ? 0 : next_tal(etal0, te, corr, ecls);
      e.cyc = acc_cyc + 12 + extra; e.cls = ecls; e.sim = esim; e.tie = etie; e.tally = etal0;
      q0.push_back(e);
    end
    @(negedge clk);
    qv0 = 1'b0;
  endtask

  task automatic send1(input logic [83:0] hv, input logic m, input int ecls, input int esim,
                       input int etie);
    exp_t e;
    int n;
    qhv1 = hv; mode1 = m; cc1 = '0; te1 = 1'b0; qv1 = 1'b1;
    n = 0;
    while (!(qr1 && en) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(qr1 && en)) begin
      check("d1_accept_timeout", int'(qr1 && en), 1);
      qv1 = 1'b0;
      return;
    end
    e.cyc = cyc + 13; e.cls = ecls; e.sim = esim; e.tie = etie; e.tally = 0;
    q1.push_back(e);
    @(negedge clk);
    qv1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || pend0 || pend1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(q0.size() + q1.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int a, prev, n;
    logic [83:0] c0_84;
    nrst = 1'b0; en = 1'b1; clear_tally = 1'b0;
    mode0 = 0; qv0 = 0; qhv0 = '0; cc0 = '0; te0 = 0;
    mode1 = 0; qv1 = 0; qhv1 = '0; cc1 = '0; te1 = 0;
    for (int c = 0; c < 26; c++) chv0[c*80 +: 80] = cls_hv(c);
    c0_84 = '0;
    for (int i = 0; i < 42; i++) c0_84[i] = 1'b1;
    chv1 = '1;
    chv1[83:0] = c0_84;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    check("rst_ready", int'(qr0), 1);
    check("rst_valid", int'(rv0), 0);
    check("rst_class", int'(ci0), 0);
    check("rst_sim", int'(bs0), 0);
    check("rst_tie", int'(tf0), 0);
    check("rst_tally", int'(tal0), 0);

    // 84-bit build: pad bits must not score under XNOR
    send1(~c0_84, 1'b1, 1, 42, 1);
    send1('1, 1'b1, 1, 84, 1);
    send1(c0_84, 1'b1, 0, 84, 0);
    send1(~c0_84, 1'b0, 1, 42, 1);
    wait_idle();

    send0(cls_hv(5), 1'b0, 5, 1'b1, 5, 3, 0, 0, 0, 1, a);
    send0(cls_hv(5), 1'b1, 5, 1'b0, 5, 80, 0, 0, 0, 1, a);
    send0(cls_hv(25), 1'b0, 3, 1'b1, 25, 3, 0, 0, 0, 1, a);
    send0('0, 1'b0, 0, 1'b1, 0, 0, 1, 0, 0, 1, a);
    wait_idle();

    chv0[7*80 +: 80] = cls_hv(3);
    send0(cls_hv(3), 1'b0, 7, 1'b1, 3, 3, 1, 0, 0, 1, a);
    send0(cls_hv(3), 1'b1, 3, 1'b0, 3, 80, 1, 0, 0, 1, a);
    wait_idle();
    chv0[7*80 +: 80] = cls_hv(7);

    // stall over ACCUM segment 4 (cycle acc+5) for four cycles
    send0(cls_hv(10), 1'b1, 10, 1'b1, 10, 80, 0, 4, 0, 1, a);
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_idle();

    en = 1'b0; clear_tally = 1'b1;
    @(negedge clk);
    clear_tally = 1'b0; en = 1'b1;
    check("clear_while_stalled", int'(tal0), 0);
    etal0 = 0;

    prev = 0;
    for (int i = 0; i < 2047; i++) begin
      send0(cls_hv(i % 26), 1'b0, i % 26, 1'b1, i % 26, 3, 0, 0, 0, 1, a);
      if (i > 0) check("back_to_back_interval", a - prev, 13);
      prev = a;
    end
    wait_idle();
    check("tally_full", int'(tal0), 2047);
    send0(cls_hv(2), 1'b0, 2, 1'b1, 2, 3, 0, 0, 0, 1, a);
    wait_idle();

    send0(cls_hv(8), 1'b0, 8, 1'b1, 8, 3, 0, 0, 1, 1, a);
    n = 0;
    while (!rv0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    clear_tally = 1'b1;
    @(negedge clk);
    clear_tally = 1'b0;
    wait_idle();

    send0(cls_hv(9), 1'b0, 9, 1'b1, 9, 3, 0, 0, 0, 1, a);
    wait_idle();

    // abort a search at cycle 6
    send0(cls_hv(4), 1'b0, 4, 1'b1, 4, 3, 0, 0, 0, 0, a);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("abort_valid", int'(rv0), 0);
    check("abort_class", int'(ci0), 0);
    check("abort_sim", int'(bs0), 0);
    check("abort_tie", int'(tf0), 0);
    check("abort_tally", int'(tal0), 0);
    check("abort_ready", int'(qr0), 1);
    nrst = 1'b1;
    etal0 = 0;
    repeat (20) @(negedge clk);
    send0(cls_hv(6), 1'b0, 6, 1'b1, 6, 3, 0, 0, 0, 1, a);
    wait_idle();

    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
